sm_controller: RTL and testbench

SM_CONTROLLER -- requirements
Module: sm_controller

---
 rtl/sm_controller.sv | 78 +++++++
 tb/tb_sm_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sm_controller.sv
// Sequencing controller for an N-bit shift-add multiplier.
// It drives the datapath load, clear, add and shift strobes from a six-state Moore FSM.
module sm_controller #(
    parameter int N = 4,
    localparam int BW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  mr,
    output logic          mdld,
    output logic          mrld,
    output logic          rsclear,
    output logic          rsload,
    output logic          rsshr,
    output logic          busy,
    output logic          done,
    output logic [BW-1:0] bitcnt
);

    typedef enum logic [2:0] {IDLE, INIT, TEST, ADD, SHIFT, DONE} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] bitcnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            bitcnt <= '0;
        end else begin
            state  <= state_nxt;
            bitcnt <= bitcnt_nxt;
        end
    end

    // The outputs depend only on the state. mr is consulted only for the TEST branch.
    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        mdld       = 1'b0;
        mrld       = 1'b0;
        rsclear    = 1'b0;
        rsload     = 1'b0;
        rsshr      = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:  if (start) state_nxt = INIT;
            INIT: begin
                mdld       = 1'b1;
                mrld       = 1'b1;
                rsclear    = 1'b1;
                bitcnt_nxt = '0;
                state_nxt  = TEST;
            end
            TEST:  state_nxt = mr[bitcnt] ? ADD : SHIFT;
            ADD: begin
                rsload    = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                rsshr = 1'b1;
                if (bitcnt == BW'(N - 1)) begin
                    state_nxt = DONE;
                end else begin
                    bitcnt_nxt = bitcnt + BW'(1);
                    state_nxt  = TEST;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sm_controller.sv
// Randomized bench for sm_controller with a small shift-add datapath attached.
// It checks the latency, the pulse counts and the product against plain arithmetic.
module tb_sm_controller;
    localparam int N  = 4;
    localparam int BW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  mr;
    logic          mdld, mrld, rsclear, rsload, rsshr, busy, done;
    logic [BW-1:0] bitcnt;

    logic [N-1:0]  opa = '0, opb = '0, md_reg, mr_reg;
    logic [2*N:0]  rs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sm_controller #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .mr(mr),
        .mdld(mdld), .mrld(mrld), .rsclear(rsclear), .rsload(rsload),
        .rsshr(rsshr), .busy(busy), .done(done), .bitcnt(bitcnt)
    );

    // The datapath keeps an extra carry bit above the running sum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            md_reg <= '0;
            mr_reg <= '0;
            rs     <= '0;
        end else begin
            if (mdld) md_reg <= opa;
            if (mrld) mr_reg <= opb;
            if (rsclear)     rs <= '0;
            else if (rsload) rs[2*N:N] <= rs[2*N:N] + {1'b0, md_reg};
            else if (rsshr)  rs <= rs >> 1;
        end
    end
    assign mr = mr_reg;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int popcnt(input logic [N-1:0] v);
        int n = 0;
        for (int i = 0; i < N; i++) n += int'(v[i]);
        return n;
    endfunction

    // Called at a negedge while the DUT is idle. It returns at the negedge of the IDLE cycle that follows DONE.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit noisy);
        int done_c = 0, nld = 0, nsh = 0, mask = 0, viol = 0;
        opa = a;
        opb = b;
        start = 1'b1;
        for (int c = 1; c <= 60 && done_c == 0; c++) begin
            @(negedge clk);
            start = (noisy && c > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == 1) chk("init_strobes", int'({mdld, mrld, rsclear, busy}), 15);
            if (rsload) begin
                nld++;
                mask |= (1 << bitcnt);
            end
            if (rsshr) nsh++;
            if ((rsload && rsshr) || (rsclear && (rsload || rsshr)) || int'(bitcnt) > N - 1 || !busy)
                viol++;
            if (done) begin
                done_c = c;
                start = 1'b0;
            end
        end
        chk("latency", done_c, 2 + 2 * N + popcnt(b));
        chk("rsload_count", nld, popcnt(b));
        chk("rsshr_count", nsh, N);
        chk("rsload_bits", mask, int'(b));
        chk("product", int'(rs[2*N-1:0]), int'(a) * int'(b));
        chk("strobe_rules", viol, 0);
        chk("bitcnt_done", int'(bitcnt), N - 1);
        @(negedge clk);
        chk("idle_outputs", int'({busy, done, mdld, mrld, rsclear, rsload, rsshr}), 0);
        chk("bitcnt_idle_hold", int'(bitcnt), N - 1);
    endtask

    initial begin
        int period, found, nd;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({busy, done, mdld, mrld, rsclear, rsload, rsshr}), 0);
        chk("reset_bitcnt", int'(bitcnt), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_start", int'(busy), 0);

        run_op(4'd9,  4'b0000, 1'b0);
        run_op(4'd15, 4'b1111, 1'b0);
        run_op(4'd7,  4'b1010, 1'b0);

        // With start held high, the operations run back to back with one IDLE cycle between them.
        opa = 4'd3;
        opb = 4'b0001;
        period = 3 + 2 * N + popcnt(opb);
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk("held_busy", int'(busy), int'((c % period) != 0));
            chk("held_done", int'(done), int'((c % period) == period - 1));
            chk("held_init", int'(mdld), int'((c % period) == 1));
        end
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (!busy) found = 1;
        end
        chk("held_drain", found, 1);

        // Reset during ADD of bit 2 aborts the operation.
        opa = 4'd5;
        opb = 4'b0111;
        start = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (rsload && bitcnt == BW'(2)) found = 1;
        end
        chk("abort_reached", found, 1);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("abort_outputs", int'({busy, done, mdld, mrld, rsclear, rsload, rsshr}), 0);
        chk("abort_bitcnt", int'(bitcnt), 0);
        rst = 1'b1;
        start = 1'b0;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("abort_quiet", nd, 0);
        run_op(4'd9, 4'd13, 1'b0);

        for (int k = 0; k < 20; k++)
            run_op(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
